semafor_ctrl: RTL and testbench
===============================

// Module: semafor_ctrl
// PURPOSE
//  Pedestrian-crossing traffic-light controller. One car signal, one pedestrian signal.
//  Cars hold green by default. A pedestrian push-button requests a crossing.
//  After a minimum car-green time, the block runs all-red -> pedestrian green -> all-red,
//  then returns to car green. Slow system tick clock (nominal 10 s period).
// PARAMETERS
//  T_MIN_MASINI  3  min car-green cycles before a request is served (>=1)
//  T_ROSU        1  all-red clearance cycles, both transitions (>=1)
//  T_PIETONI     2  pedestrian-green cycles (>=1)
//  CNT_W         4  phase-counter width; must hold max(T_*)
// PORTS
//  clk              in   1  system clock; single clock domain for all state
//  rst_n            in   1  reset; asynchronous, active-low
//  buton            in   1  pedestrian button; asynchronous, pulses may be << one clk period
//  semafor_masini   out  1  1 = car green, 0 = car red
//  semafor_pietoni  out  1  1 = pedestrian green, 0 = pedestrian red
// BEHAVIOUR
//  Reset (rst_n=0): state=MASINI, counter=0, request cleared.
//   Outputs during reset: semafor_masini=1, semafor_pietoni=0.
//   buton (including X) is ignored while rst_n=0.
//  Request capture: buton is not sampled by clk.
//   - req_ff is set by the rising edge of buton (D=1).
//   - req_ff is asynchronously cleared while (!rst_n | clr_req).
//   - clr_req is a clk-domain register, 1 in every state except MASINI.
//   - req_ff feeds a 2-flop synchronizer (async reset to 0) -> req_s.
//   - A 1 s pulse between clk edges must be captured.
//  States and transitions:
//   MASINI  (masini=1, pietoni=0)
//     - cnt counts up from entry, saturating at T_MIN_MASINI.
//     - Goes to ROSU1 when req_s=1 and cnt==T_MIN_MASINI.
//     - If req_s rises later, leaves on the next edge once saturated.
//   ROSU1   (0,0)  T_ROSU cycles, then -> PIETONI
//   PIETONI (0,1)  T_PIETONI cycles, then -> ROSU2
//   ROSU2   (0,0)  T_ROSU cycles, then -> MASINI; cnt restarts at 0
//  cnt reloads to 0 on every state change.
//  Outputs are registered, decoded from state; both 1 at once is illegal.
//  Presses outside MASINI are discarded, not queued.
//  Multiple presses inside MASINI collapse into one request.
//  Latency: button edge -> req_s = 2-3 clk edges. ROSU1 is entered at the first edge with
//   req_s=1 and counter saturated.
//  Reset mid-phase: immediate return to MASINI outputs; pending request is lost.
// STRUCTURE
//  Package semafor_pkg: state enum {MASINI,ROSU1,PIETONI,ROSU2}, default T_* constants.
//  Sub-module semafor_cerere: req_ff + 2-flop sync; ports clk, rst_n, buton, clr_req, req_s.
//  Top: FSM, phase counter, output registers.
// TESTING (clk period 10, defaults)
//  - Reset with buton=X -> masini=1, pietoni=0 throughout reset and after; no crossing starts.
//  - 1-unit press right after a clk edge, >=3 cycles after reset:
//    -> ROSU1 within 3 edges, PIETONI for exactly 2 cycles, ROSU2 1 cycle, then masini=1.
//  - Press at cycle 0 of MASINI:
//    -> crossing starts only after cnt reaches 3; car green lasts >=3 cycles.
//  - Presses during ROSU1/PIETONI/ROSU2 -> ignored; no second crossing after return.
//  - Two presses 3 units apart within MASINI -> exactly one crossing.
//  - Press held 3 units, then presses 30/22 units later -> one crossing each when in MASINI.
//  - Throughout: never masini=1 and pietoni=1 together.
//  - rst_n=0 during PIETONI -> masini=1 asynchronously, pietoni=0.

Source files
------------

// File: rtl/semafor_pkg.sv
// Shared types and default timing for the pedestrian-crossing controller.
//  stare_e      : controller phases, in the order they are visited
//  *_DEF        : default phase lengths in clk cycles and counter width
package semafor_pkg;

    typedef enum logic [1:0] {
        MASINI  = 2'd0,
        ROSU1   = 2'd1,
        PIETONI = 2'd2,
        ROSU2   = 2'd3
    } stare_e;

    localparam int unsigned T_MIN_MASINI_DEF = 3;
    localparam int unsigned T_ROSU_DEF       = 1;
    localparam int unsigned T_PIETONI_DEF    = 2;
    localparam int unsigned CNT_W_DEF        = 4;

endpackage

// File: rtl/semafor_cerere.sv
// Pedestrian request capture: edge-triggered latch on the raw button followed
// by a two-flop synchronizer into the clk domain.
//  clk      in   system clock
//  rst_n    in   asynchronous active-low reset
//  buton    in   raw pedestrian button, asynchronous, possibly very short pulses
//  clr_req  in   clk-domain clear, high while a crossing is in progress
//  req_s    out  synchronized request
module semafor_cerere (
    input  logic clk,
    input  logic rst_n,
    input  logic buton,
    input  logic clr_req,
    output logic req_s
);

    logic clr_a;
    logic req_ff;
    logic sync1_q;
    logic sync2_q;

    // Held clear during reset and for the whole crossing, so presses there are dropped.
    assign clr_a = ~rst_n | clr_req;

    // Button edge acts as the clock, so pulses shorter than a clk period are kept.
    always_ff @(posedge buton or posedge clr_a) begin
        if (clr_a) begin
            req_ff <= 1'b0;
        end else begin
            req_ff <= 1'b1;
        end
    end

    // Two-flop synchronizer into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= req_ff;
            sync2_q <= sync1_q;
        end
    end

    assign req_s = sync2_q;

endmodule

// File: rtl/semafor_ctrl.sv
// Pedestrian-crossing traffic-light controller. Cars hold green; a button press
// runs all-red -> pedestrian green -> all-red once the minimum car green elapsed.
//  clk              in   system tick clock
//  rst_n            in   asynchronous active-low reset
//  buton            in   raw pedestrian button (asynchronous)
//  semafor_masini   out  1 = car green (registered)
//  semafor_pietoni  out  1 = pedestrian green (registered)
module semafor_ctrl
    import semafor_pkg::*;
#(
    parameter int unsigned T_MIN_MASINI = T_MIN_MASINI_DEF,
    parameter int unsigned T_ROSU       = T_ROSU_DEF,
    parameter int unsigned T_PIETONI    = T_PIETONI_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic buton,
    output logic semafor_masini,
    output logic semafor_pietoni
);

    localparam logic [CNT_W-1:0] CNT_MIN_MASINI = CNT_W'(T_MIN_MASINI);
    localparam logic [CNT_W-1:0] CNT_ROSU_END   = CNT_W'(T_ROSU - 1);
    localparam logic [CNT_W-1:0] CNT_PIET_END   = CNT_W'(T_PIETONI - 1);
    localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);

    stare_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             masini_q, masini_d;
    logic             pietoni_q, pietoni_d;
    logic             clr_req_q, clr_req_d;
    logic             req_s;

    semafor_cerere u_cerere (
        .clk     (clk),
        .rst_n   (rst_n),
        .buton   (buton),
        .clr_req (clr_req_q),
        .req_s   (req_s)
    );

    // Next-state, phase counter and decoded outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        masini_d  = 1'b0;
        pietoni_d = 1'b0;
        clr_req_d = 1'b0;

        case (state_q)
            MASINI: begin
                if (req_s && (cnt_q == CNT_MIN_MASINI)) begin
                    state_d = ROSU1;
                    cnt_d   = '0;
                end else if (cnt_q != CNT_MIN_MASINI) begin
                    // Saturate so a late request leaves on the very next edge.
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ROSU1: begin
                if (cnt_q == CNT_ROSU_END) begin
                    state_d = PIETONI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PIETONI: begin
                if (cnt_q == CNT_PIET_END) begin
                    state_d = ROSU2;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ROSU2: begin
                if (cnt_q == CNT_ROSU_END) begin
                    state_d = MASINI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = MASINI;
                cnt_d   = '0;
            end
        endcase

        // Outputs and request clear are decoded from the next state so the
        // registers line up with state_q.
        masini_d  = (state_d == MASINI);
        pietoni_d = (state_d == PIETONI);
        clr_req_d = (state_d != MASINI);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MASINI;
            cnt_q     <= '0;
            masini_q  <= 1'b1;
            pietoni_q <= 1'b0;
            clr_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            masini_q  <= masini_d;
            pietoni_q <= pietoni_d;
            clr_req_q <= clr_req_d;
        end
    end

    assign semafor_masini  = masini_q;
    assign semafor_pietoni = pietoni_q;

endmodule

// File: tb/tb_semafor_ctrl.sv
// Directed bench for semafor_ctrl with default timing (3/1/2), clk period 10.
// Outputs are sampled on the falling clk edge; {masini,pietoni}: 10 car green,
// 00 all red, 01 pedestrian green.
module tb_semafor_ctrl;

    logic clk;
    logic rst_n;
    logic buton;
    logic semafor_masini;
    logic semafor_pietoni;

    int n_tests = 0;
    int n_fail  = 0;

    semafor_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .buton           (buton),
        .semafor_masini  (semafor_masini),
        .semafor_pietoni (semafor_pietoni)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Both lights green at once is never allowed.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            n_tests++;
            if (semafor_masini === 1'b1 && semafor_pietoni === 1'b1) begin
                n_fail++;
                $display("FAIL both_green at %0t: got masini=1 pietoni=1, required not both 1", $time);
            end
        end
    end

    initial begin
        #60000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        logic [1:0] obs;
        rst_n = 1'b1;
        buton = 1'b0;
        #2;
        rst_n = 1'b0;
        buton = 1'bx;
        #1;
        obs = {semafor_masini, semafor_pietoni};
        n_tests++;
        if (obs !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_async: got %b required 10", obs);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            buton = (i == 1) ? 1'b1 : 1'bx;
            obs = {semafor_masini, semafor_pietoni};
            n_tests++;
            if (obs !== 2'b10) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got %b required 10", i, obs);
            end
        end
        buton = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            obs = {semafor_masini, semafor_pietoni};
            n_tests++;
            if (obs !== 2'b10) begin
                n_fail++;
                $display("FAIL reset_no_crossing[%0d]: got %b required 10", i, obs);
            end
        end
    endtask

    // 1-unit press right after edge E0 with car green saturated.
    task automatic test_single_press();
        logic [1:0] obs;
        logic [1:0] exp [12];
        exp = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01,
                2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
        @(posedge clk);
        #1 buton = 1'b1;
        #1 buton = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            obs = {semafor_masini, semafor_pietoni};
            n_tests++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("FAIL single_press[%0d]: got %b required %b", i, obs, exp[i]);
            end
        end
    endtask

    // Press during cycle 0 of car green (just after reset): wait for cnt to reach 3.
    task automatic test_min_green();
        logic [1:0] obs;
        logic [1:0] exp [12];
        exp = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01,
                2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
        @(negedge clk);
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        #1 buton = 1'b1;
        #1 buton = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            obs = {semafor_masini, semafor_pietoni};
            n_tests++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("FAIL min_green[%0d]: got %b required %b", i, obs, exp[i]);
            end
        end
    endtask

    // Presses in ROSU1, PIETONI and ROSU2 are dropped.
    task automatic test_press_during_crossing();
        logic [1:0] obs;
        logic [1:0] exp [14];
        logic       prs [14];
        exp = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00,
                2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
        prs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        @(posedge clk);
        #1 buton = 1'b1;
        #1 buton = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            obs = {semafor_masini, semafor_pietoni};
            n_tests++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("FAIL press_in_crossing[%0d]: got %b required %b", i, obs, exp[i]);
            end
            if (prs[i]) begin
                #1 buton = 1'b1;
                #1 buton = 1'b0;
            end
        end
    endtask

    // Two presses 3 units apart in car green collapse into one crossing.
    task automatic test_two_presses();
        logic [1:0] obs;
        logic [1:0] exp [12];
        exp = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00,
                2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
        @(posedge clk);
        fork
            begin
                #1 buton = 1'b1;
                #1 buton = 1'b0;
                #3 buton = 1'b1;
                #1 buton = 1'b0;
            end
        join_none
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            obs = {semafor_masini, semafor_pietoni};
            n_tests++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("FAIL two_presses[%0d]: got %b required %b", i, obs, exp[i]);
            end
        end
    endtask

    // 3-unit press, then presses 30 and 22 units later land in ROSU1 and PIETONI.
    task automatic test_long_press();
        logic [1:0] obs;
        logic [1:0] exp [14];
        exp = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00,
                2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
        @(posedge clk);
        fork
            begin
                #1  buton = 1'b1;
                #3  buton = 1'b0;
                #27 buton = 1'b1;
                #1  buton = 1'b0;
                #21 buton = 1'b1;
                #1  buton = 1'b0;
            end
        join_none
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            obs = {semafor_masini, semafor_pietoni};
            n_tests++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("FAIL long_press[%0d]: got %b required %b", i, obs, exp[i]);
            end
        end
    endtask

    // Press right after the return to car green starts a second crossing.
    task automatic test_back_to_back();
        logic [1:0] obs;
        logic [1:0] exp [18];
        exp = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00,
                2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01,
                2'b00, 2'b10, 2'b10, 2'b10};
        @(posedge clk);
        fork
            begin
                #1  buton = 1'b1;
                #1  buton = 1'b0;
                #69 buton = 1'b1;
                #1  buton = 1'b0;
            end
        join_none
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            obs = {semafor_masini, semafor_pietoni};
            n_tests++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %b required %b", i, obs, exp[i]);
            end
        end
    endtask

    // Reset during pedestrian green, then reset dropping a pending request.
    task automatic test_reset_mid_ped();
        logic [1:0] obs;
        logic [1:0] exp [5];
        exp = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
        @(posedge clk);
        #1 buton = 1'b1;
        #1 buton = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            obs = {semafor_masini, semafor_pietoni};
            n_tests++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("FAIL mid_ped_lead[%0d]: got %b required %b", i, obs, exp[i]);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        obs = {semafor_masini, semafor_pietoni};
        n_tests++;
        if (obs !== 2'b10) begin
            n_fail++;
            $display("FAIL mid_ped_async_reset: got %b required 10", obs);
        end
        @(posedge clk);
        #1;
        obs = {semafor_masini, semafor_pietoni};
        n_tests++;
        if (obs !== 2'b10) begin
            n_fail++;
            $display("FAIL mid_ped_reset_hold: got %b required 10", obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        // Pending request half-way through the synchronizer is wiped by reset.
        #1 buton = 1'b1;
        #1 buton = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            obs = {semafor_masini, semafor_pietoni};
            n_tests++;
            if (obs !== 2'b10) begin
                n_fail++;
                $display("FAIL request_lost[%0d]: got %b required 10", i, obs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_min_green();
        test_press_during_crossing();
        test_two_presses();
        test_long_press();
        test_back_to_back();
        test_reset_mid_ped();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
